// File: rtl/gol_next_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : gol_next_gen_if
//  Description : Control and register-file bus of the Game of Life generation
//                engine. The master side is the engine: it receives start and
//                read data, and drives status, read address and write port.
//                The slave side is the host plus the current_state register
//                file.
//  Revision    : 1.0  initial release
// ============================================================================
interface gol_next_gen_if #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3
);
  logic               start;
  logic               busy;
  logic               done;
  logic [REGBITS-1:0] ra;
  logic [WIDTH-1:0]   rd;
  logic               regwrite;
  logic [REGBITS-1:0] wa;
  logic [WIDTH-1:0]   wd;
  logic [15:0]        gen_count;
  logic               stable;

  modport master (
    input  start, rd,
    output busy, done, ra, regwrite, wa, wd, gen_count, stable
  );

  modport slave (
    output start, rd,
    input  busy, done, ra, regwrite, wa, wd, gen_count, stable
  );
endinterface
`default_nettype wire

// File: rtl/gol_next_gen.sv
`default_nettype none
// ============================================================================
//  Module      : gol_next_gen
//  Description : Computes one B3/S23 generation of the board held in the
//                current_state register file, row by row, writing each new
//                row back in place. Original rows live in a prev/cur/nxt
//                sliding window (plus a copy of row 0) so in-place writes
//                never corrupt rows still needed as neighbours.
//  Options     : GOL_TORUS_WRAP_EN - when defined the board is a torus,
//                otherwise everything outside the board is dead.
//  Revision    : 1.0  initial release
// ============================================================================
module gol_next_gen #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3
) (
  input  wire logic      ph2,
  input  wire logic      reset_n,
  gol_next_gen_if.master bus
);

  localparam int ROWS = 2 ** REGBITS;
  localparam logic [REGBITS-1:0] LAST_ROW = REGBITS'(ROWS - 1);
  localparam logic [REGBITS-1:0] ONE_ROW  = REGBITS'(1);

`ifdef GOL_TORUS_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRIME_TOP = 3'd1,
    S_PRIME0    = 3'd2,
    S_READ      = 3'd3,
    S_WRITE     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [REGBITS-1:0] row_q, row_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [WIDTH-1:0]   cur_q, cur_d;
  logic [WIDTH-1:0]   nxt_q, nxt_d;
  logic [WIDTH-1:0]   first_q, first_d;
  logic               chg_q, chg_d;
  logic [15:0]        gen_count_q, gen_count_d;
  logic               stable_q, stable_d;

  // Row extended by one column on each side: bit 0 is column -1 and
  // bit WIDTH+1 is column WIDTH, so every cell sees a uniform 3-bit span.
  function automatic logic [WIDTH+1:0] pad_row(input logic [WIDTH-1:0] row);
    if (WRAP_EN) begin
      return {row[0], row, row[WIDTH-1]};
    end
    return {1'b0, row, 1'b0};
  endfunction

  logic [WIDTH+1:0] ext_prev;
  logic [WIDTH+1:0] ext_cur;
  logic [WIDTH+1:0] ext_nxt;
  logic [WIDTH-1:0] new_row;

  assign ext_prev = pad_row(prev_q);
  assign ext_cur  = pad_row(cur_q);
  assign ext_nxt  = pad_row(nxt_q);

  // Per-cell neighbour count and B3/S23 rule on the current window
  for (genvar c = 0; c < WIDTH; c++) begin : g_cell
    logic [3:0] n;
    assign n = 4'(ext_prev[c]) + 4'(ext_prev[c+1]) + 4'(ext_prev[c+2])
             + 4'(ext_cur[c])                      + 4'(ext_cur[c+2])
             + 4'(ext_nxt[c])  + 4'(ext_nxt[c+1])  + 4'(ext_nxt[c+2]);
    assign new_row[c] = (n == 4'd3) | (ext_cur[c+1] & (n == 4'd2));
  end

  // Next-state, window updates and bus outputs for each phase of a generation
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    prev_d      = prev_q;
    cur_d       = cur_q;
    nxt_d       = nxt_q;
    first_d     = first_q;
    chg_d       = chg_q;
    gen_count_d = gen_count_q;
    stable_d    = stable_q;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.ra       = '0;
    bus.regwrite = 1'b0;
    bus.wa       = '0;
    bus.wd       = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_PRIME_TOP;
          row_d   = '0;
          chg_d   = 1'b0;
        end
      end
      S_PRIME_TOP: begin
        // Address is driven in both modes so cycle timing is identical
        bus.busy = 1'b1;
        bus.ra   = LAST_ROW;
        prev_d   = WRAP_EN ? bus.rd : '0;
        state_d  = S_PRIME0;
      end
      S_PRIME0: begin
        bus.busy = 1'b1;
        bus.ra   = '0;
        cur_d    = bus.rd;
        first_d  = bus.rd;
        state_d  = S_READ;
      end
      S_READ: begin
        bus.busy = 1'b1;
        if (row_q != LAST_ROW) begin
          bus.ra = row_q + ONE_ROW;
          nxt_d  = bus.rd;
        end else begin
          // Row 0 has already been overwritten; use the saved original
          nxt_d = WRAP_EN ? first_q : '0;
        end
        state_d = S_WRITE;
      end
      S_WRITE: begin
        bus.busy     = 1'b1;
        bus.regwrite = 1'b1;
        bus.wa       = row_q;
        bus.wd       = new_row;
        prev_d       = cur_q;
        cur_d        = nxt_q;
        row_d        = row_q + ONE_ROW;
        chg_d        = chg_q | (new_row != cur_q);
        state_d      = (row_q == LAST_ROW) ? S_DONE : S_READ;
      end
      S_DONE: begin
        bus.done    = 1'b1;
        gen_count_d = gen_count_q + 16'd1;
        stable_d    = ~chg_q;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and window registers with synchronous active-low reset
  always_ff @(posedge ph2) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      prev_q      <= '0;
      cur_q       <= '0;
      nxt_q       <= '0;
      first_q     <= '0;
      chg_q       <= 1'b0;
      gen_count_q <= '0;
      stable_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      nxt_q       <= nxt_d;
      first_q     <= first_d;
      chg_q       <= chg_d;
      gen_count_q <= gen_count_d;
      stable_q    <= stable_d;
    end
  end

  assign bus.gen_count = gen_count_q;
  assign bus.stable    = stable_q;

endmodule
`default_nettype wire

// File: tb/tb_gol_next_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gol_next_gen
//  Description : Self-checking bench for gol_next_gen. Holds the register
//                file, a cell-by-cell Game of Life reference model, and
//                drives directed and random boards through the engine.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gol_next_gen;

  localparam int WIDTH   = 8;
  localparam int REGBITS = 3;
  localparam int ROWS    = 2 ** REGBITS;

`ifdef GOL_TORUS_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  gol_next_gen_if #(.WIDTH(WIDTH), .REGBITS(REGBITS)) bus ();

  gol_next_gen #(.WIDTH(WIDTH), .REGBITS(REGBITS)) dut (
    .ph2    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // current_state register file: combinational read, clocked write
  logic [WIDTH-1:0] mem        [ROWS];
  logic [WIDTH-1:0] load_board [ROWS];
  logic             load_en;

  assign bus.rd = mem[bus.ra];

  // Register file write port, also used by the bench to preload a board
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < ROWS; i++) mem[i] <= load_board[i];
    end else if (bus.regwrite) begin
      mem[bus.wa] <= bus.wd;
    end
  end

  // Reference board and expected status
  logic [WIDTH-1:0] model [ROWS];
  int               exp_gen;
  bit               exp_stable;
  int               n_tests;
  int               n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit cell_at(input int r, input int c);
    int rr;
    int cc;
    if (WRAP) begin
      rr = (r + ROWS) % ROWS;
      cc = (c + WIDTH) % WIDTH;
    end else begin
      if (r < 0 || r >= ROWS || c < 0 || c >= WIDTH) return 1'b0;
      rr = r;
      cc = c;
    end
    return model[rr][cc];
  endfunction

  task automatic model_step();
    logic [WIDTH-1:0] nb [ROWS];
    bit changed;
    changed = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0) n += int'(cell_at(r + dr, c + dc));
        nb[r][c] = (n == 3) || (model[r][c] && n == 2);
      end
      if (nb[r] != model[r]) changed = 1'b1;
    end
    for (int r = 0; r < ROWS; r++) model[r] = nb[r];
    exp_stable = !changed;
    exp_gen    = (exp_gen + 1) % 65536;
  endtask

  task automatic clear_model();
    for (int r = 0; r < ROWS; r++) model[r] = '0;
  endtask

  task automatic load_mem();
    @(negedge clk);
    for (int r = 0; r < ROWS; r++) load_board[r] = model[r];
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // One generation; ctrl adds start pulses while busy and in DONE
  task automatic run_gen(input string tag, input bit ctrl);
    int busy_cnt;
    int wr_cnt;
    int done_cyc;
    int extra;
    bit wa_ok;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    busy_cnt = 0;
    wr_cnt   = 0;
    done_cyc = 0;
    wa_ok    = 1'b1;
    for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      bus.start = ctrl && (cyc == 5 || cyc == 12);
      if (bus.busy) busy_cnt++;
      if (bus.regwrite) begin
        if (int'(bus.wa) != wr_cnt) wa_ok = 1'b0;
        wr_cnt++;
      end
      if (bus.done) begin
        done_cyc  = cyc;
        bus.start = ctrl;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    model_step();
    chk($sformatf("%s_done_cycle", tag), done_cyc, 19);
    chk($sformatf("%s_busy_cycles", tag), busy_cnt, 2 + 2 * ROWS);
    chk($sformatf("%s_writes", tag), wr_cnt, ROWS);
    chk($sformatf("%s_wa_order", tag), wa_ok, 1);
    chk($sformatf("%s_gen_count", tag), bus.gen_count, exp_gen);
    chk($sformatf("%s_stable", tag), bus.stable, exp_stable);
    for (int r = 0; r < ROWS; r++)
      chk($sformatf("%s_row%0d", tag, r), mem[r], model[r]);
    if (ctrl) begin
      extra = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (bus.busy || bus.regwrite || bus.done) extra++;
      end
      chk($sformatf("%s_no_requeue", tag), extra, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk($sformatf("%s_busy", tag), bus.busy, 0);
    chk($sformatf("%s_done", tag), bus.done, 0);
    chk($sformatf("%s_regwrite", tag), bus.regwrite, 0);
    chk($sformatf("%s_ra", tag), bus.ra, 0);
    chk($sformatf("%s_wa", tag), bus.wa, 0);
    chk($sformatf("%s_wd", tag), bus.wd, 0);
    chk($sformatf("%s_gen_count", tag), bus.gen_count, 0);
    chk($sformatf("%s_stable", tag), bus.stable, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_after;
    n_tests    = 0;
    n_fail     = 0;
    exp_gen    = 0;
    exp_stable = 1'b0;
    load_en    = 1'b0;
    bus.start  = 1'b1;
    reset_n    = 1'b0;
    for (int r = 0; r < ROWS; r++) load_board[r] = '0;

    // Reset held with start asserted
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    bus.start = 1'b0;
    reset_n   = 1'b1;

    // Blinker across rows 1..3
    clear_model();
    model[2] = 8'b00111000;
    load_mem();
    run_gen("blinker", 1'b0);
    chk("blinker_r1_const", mem[1], 8'b00010000);
    chk("blinker_r2_const", mem[2], 8'b00010000);
    chk("blinker_r3_const", mem[3], 8'b00010000);
    chk("blinker_r0_const", mem[0], 8'b00000000);

    // Block still life, two generations
    clear_model();
    model[3] = 8'b00011000;
    model[4] = 8'b00011000;
    load_mem();
    run_gen("still1", 1'b0);
    run_gen("still2", 1'b0);
    chk("still_stable_const", bus.stable, 1);
    chk("still_r3_const", mem[3], 8'b00011000);

    // Row edge
    clear_model();
    model[0] = 8'b00111000;
    load_mem();
    run_gen("row_edge", 1'b0);

    // Column edge
    clear_model();
    model[4] = 8'b10000011;
    load_mem();
    run_gen("col_edge", 1'b0);

    // Ignored start pulses while busy and in DONE
    clear_model();
    model[5] = 8'b01110000;
    model[6] = 8'b00001110;
    load_mem();
    run_gen("control", 1'b1);

    // Random boards, continuing some for a second generation
    for (int t = 0; t < 12; t++) begin
      clear_model();
      for (int r = 0; r < ROWS; r++)
        model[r] = WIDTH'($urandom & $urandom_range(255, 0));
      load_mem();
      run_gen($sformatf("rand%0d", t), 1'b0);
      if ($urandom_range(1, 0) == 1) run_gen($sformatf("rand%0d_b", t), 1'b0);
    end

    // Reset in the middle of a generation
    clear_model();
    model[2] = 8'b00111000;
    load_mem();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    wr_after = 0;
    @(negedge clk);
    if (bus.regwrite || bus.busy) wr_after++;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.regwrite || bus.busy) wr_after++;
    end
    chk("midreset_no_write", wr_after, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
